// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of alu_arbiter: two packed request ports sharing one
// response bus. The arbiter takes the slave view; the requesters take the master view.
interface alu_arbiter_if #(
    parameter int DW = 32
);
    logic [1:0]      req_valid;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [3:0]      req_op;
    logic [7:0]      req_shift;
    logic [1:0]      req_ready;
    logic [1:0]      resp_valid;
    logic [DW-1:0]   resp_data;
    logic [1:0]      resp_ready;

    modport master (
        output req_valid, req_a, req_b, req_op, req_shift, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_shift, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC samples the ALU, RESP holds the result.
module alu_arbiter #(
    parameter int DW         = 32,  // must match the ALU width
    parameter int FIRST_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  req_if,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [1:0]    alu_op,
    output logic [3:0]    alu_shift,
    input  logic [DW-1:0] alu_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // last_grant starts on the opposite requester so FIRST_PRIO wins the first tie.
    localparam logic RESET_LAST_GRANT = (FIRST_PRIO == 0);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [1:0]    alu_op_q, alu_op_d;
    logic [3:0]    alu_shift_q, alu_shift_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic [1:0]    resp_valid_q, resp_valid_d;
    logic          busy_q, busy_d;

    logic          winner;
    logic          accept;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic [1:0]    sel_op;
    logic [3:0]    sel_shift;

    always_comb begin
        case (req_if.req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
    end

    assign accept = (state_q == IDLE) && (|req_if.req_valid) && !rst;

    assign sel_a     = winner ? req_if.req_a[2*DW-1:DW] : req_if.req_a[DW-1:0];
    assign sel_b     = winner ? req_if.req_b[2*DW-1:DW] : req_if.req_b[DW-1:0];
    assign sel_op    = winner ? req_if.req_op[3:2]      : req_if.req_op[1:0];
    assign sel_shift = winner ? req_if.req_shift[7:4]   : req_if.req_shift[3:0];

    always_comb begin
        // NOTE: every _d takes its held value first, so no path through the case can infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_shift_d  = alu_shift_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d     = sel_a;
                    alu_b_d     = sel_b;
                    alu_op_d    = sel_op;
                    alu_shift_d = sel_shift;
                    owner_d     = winner;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = alu_out;
                resp_valid_d = 2'b01 << owner_q;
                last_grant_d = owner_q;
                state_d      = RESP;
            end
            RESP: begin
                // Only the owner's ready bit completes the handshake.
                if (req_if.resp_ready[owner_q]) begin
                    resp_valid_d = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the pre-edge values of the others.
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= RESET_LAST_GRANT;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_shift_q  <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_shift_q  <= alu_shift_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_if.req_ready  = accept ? (2'b01 << winner) : 2'b00;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_data  = resp_data_q;

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_shift = alu_shift_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: an ALU model feeds alu_out, and a transaction-level model
// (one outstanding op, age counter, round-robin pointer) predicts every output each cycle.
module tb_alu_arbiter;
    localparam int DW         = 32;
    localparam int FIRST_PRIO = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [1:0]    alu_op;
    logic [3:0]    alu_shift;
    logic          busy;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DW(DW)) bus ();

    alu_arbiter #(.DW(DW), .FIRST_PRIO(FIRST_PRIO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_if    (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_shift (alu_shift),
        .alu_out   (alu_out),
        .busy      (busy)
    );

    // ALU: and/or/xor/add, then the low `shift` bits of the result are cleared.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op, input logic [3:0] sh);
        logic [31:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = a + b;
        endcase
        return r & ~((32'h1 << sh) - 32'h1);
    endfunction

    always_comb alu_out = alu_ref(alu_a, alu_b, alu_op, alu_shift);

    // Requester side
    logic [1:0]  pend_valid;
    logic [31:0] pend_a [2];
    logic [31:0] pend_b [2];
    logic [1:0]  pend_op [2];
    logic [3:0]  pend_sh [2];
    logic [1:0]  refill;
    logic [1:0]  rdy;

    // Reference model
    bit          m_active;
    int          m_owner, m_age, m_last;
    logic [31:0] m_result, m_resp_data;
    logic [31:0] m_alu_a, m_alu_b;
    logic [1:0]  m_alu_op;
    logic [3:0]  m_alu_sh;
    int          grants[$];
    int          accept_cyc[$];
    int          cyc;

    // Values sampled in the most recent cycle
    logic [1:0]  s_req_ready, s_resp_valid;
    logic [31:0] s_resp_data, s_alu_a;
    logic [3:0]  s_alu_shift;
    logic        s_busy;

    int tests = 0;
    int fails = 0;

    task automatic model_reset();
        m_active    = 1'b0;
        m_owner     = 0;
        m_age       = 0;
        m_last      = 1 - FIRST_PRIO;
        m_result    = '0;
        m_resp_data = '0;
        m_alu_a     = '0;
        m_alu_b     = '0;
        m_alu_op    = '0;
        m_alu_sh    = '0;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [3:0] sh);
        pend_valid[p] = 1'b1;
        pend_a[p]     = a;
        pend_b[p]     = b;
        pend_op[p]    = op;
        pend_sh[p]    = sh;
    endtask

    task automatic new_req(input int p);
        logic [3:0] sh;
        sh = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        set_req(p, $urandom, $urandom, 2'($urandom_range(0, 3)), sh);
    endtask

    // One clock: drive, compare every output against the model, advance the model.
    task automatic cycle();
        logic [1:0] exp_ready, exp_rv;
        int win;
        bus.req_valid  = pend_valid;
        bus.req_a      = {pend_a[1], pend_a[0]};
        bus.req_b      = {pend_b[1], pend_b[0]};
        bus.req_op     = {pend_op[1], pend_op[0]};
        bus.req_shift  = {pend_sh[1], pend_sh[0]};
        bus.resp_ready = rdy;
        #1;
        exp_ready = 2'b00;
        win = 0;
        if (!m_active && pend_valid != 2'b00 && !rst) begin
            if (pend_valid == 2'b11) win = 1 - m_last;
            else                     win = pend_valid[1] ? 1 : 0;
            exp_ready[win] = 1'b1;
        end
        exp_rv = (m_active && m_age >= 2) ? 2'(1 << m_owner) : 2'b00;

        s_req_ready  = bus.req_ready;
        s_resp_valid = bus.resp_valid;
        s_resp_data  = bus.resp_data;
        s_busy       = busy;
        s_alu_a      = alu_a;
        s_alu_shift  = alu_shift;

        tests++;
        if (bus.req_ready !== exp_ready) begin
            fails++; $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, bus.req_ready, exp_ready);
        end
        tests++;
        if (bus.resp_valid !== exp_rv) begin
            fails++; $display("FAIL resp_valid cyc=%0d: got %b expected %b", cyc, bus.resp_valid, exp_rv);
        end
        tests++;
        if (bus.resp_data !== m_resp_data) begin
            fails++; $display("FAIL resp_data cyc=%0d: got %h expected %h", cyc, bus.resp_data, m_resp_data);
        end
        tests++;
        if (busy !== m_active) begin
            fails++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, m_active);
        end
        tests++;
        if ({alu_a, alu_b, alu_op, alu_shift} !== {m_alu_a, m_alu_b, m_alu_op, m_alu_sh}) begin
            fails++;
            $display("FAIL alu_inputs cyc=%0d: got %h/%h/%b/%b expected %h/%h/%b/%b", cyc,
                     alu_a, alu_b, alu_op, alu_shift, m_alu_a, m_alu_b, m_alu_op, m_alu_sh);
        end

        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (!m_active) begin
            if (exp_ready != 2'b00) begin
                m_active = 1'b1;
                m_owner  = win;
                m_age    = 1;
                m_alu_a  = pend_a[win];
                m_alu_b  = pend_b[win];
                m_alu_op = pend_op[win];
                m_alu_sh = pend_sh[win];
                m_result = alu_ref(pend_a[win], pend_b[win], pend_op[win], pend_sh[win]);
                grants.push_back(win);
                accept_cyc.push_back(cyc - 1);
                if (refill[win]) new_req(win);
                else             pend_valid[win] = 1'b0;
            end
        end else if (m_age == 1) begin
            m_age       = 2;
            m_resp_data = m_result;
            m_last      = m_owner;
        end else if (rdy[m_owner]) begin
            m_active = 1'b0;
        end
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        refill = 2'b00;
        rdy    = 2'b11;
        while ((m_active || pend_valid != 2'b00) && n < 50) begin
            cycle();
            n++;
        end
        tests++;
        if (m_active || pend_valid != 2'b00) begin
            fails++; $display("FAIL drain_timeout: got pending=%b active=%0d expected idle", pend_valid, m_active);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        pend_valid = 2'b00;
        refill     = 2'b00;
        rdy        = 2'b00;
        for (int p = 0; p < 2; p++) set_req(p, '0, '0, '0, '0);
        pend_valid = 2'b00;
        bus.req_valid = 2'b00;
        bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.req_shift = '0; bus.resp_ready = '0;
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        set_req(1, 32'h1, 32'h2, 2'b11, 4'd0);  // request during reset must not be accepted
        cycle();
        rst = 1'b0;
        tests++;
        if (s_req_ready !== 2'b00) begin
            fails++; $display("FAIL reset_req_ready: got %b expected 00", s_req_ready);
        end
        tests++;
        if ({s_busy, s_resp_valid, s_resp_data, s_alu_a} !== '0) begin
            fails++; $display("FAIL reset_outputs: got busy=%b rv=%b rd=%h a=%h expected all zero",
                              s_busy, s_resp_valid, s_resp_data, s_alu_a);
        end
        drain();
    endtask

    task automatic test_single();
        rdy = 2'b01;
        set_req(0, 32'd5, 32'd3, 2'b11, 4'b0000);
        cycle();
        tests++;
        if (s_req_ready !== 2'b01) begin
            fails++; $display("FAIL single_accept: got %b expected 01", s_req_ready);
        end
        cycle();
        tests++;
        if (s_busy !== 1'b1 || s_resp_valid !== 2'b00) begin
            fails++; $display("FAIL single_exec: got busy=%b rv=%b expected 1/00", s_busy, s_resp_valid);
        end
        cycle();
        tests++;
        if (s_resp_valid !== 2'b01 || s_resp_data !== 32'd8) begin
            fails++; $display("FAIL single_resp: got %b/%h expected 01/00000008", s_resp_valid, s_resp_data);
        end
        cycle();
        tests++;
        if (s_busy !== 1'b0) begin
            fails++; $display("FAIL single_idle: got busy=%b expected 0", s_busy);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        grants.delete();
        rdy = 2'b11;
        set_req(0, 32'hF0, 32'h3C, 2'b00, 4'd0);
        set_req(1, 32'hFF, 32'h0F, 2'b10, 4'd0);
        cycle(); cycle(); cycle();
        tests++;
        if (s_resp_valid !== 2'b01 || s_resp_data !== 32'h30) begin
            fails++; $display("FAIL tie_first: got %b/%h expected 01/00000030", s_resp_valid, s_resp_data);
        end
        cycle(); cycle(); cycle();
        tests++;
        if (s_resp_valid !== 2'b10 || s_resp_data !== 32'hF0) begin
            fails++; $display("FAIL tie_second: got %b/%h expected 10/000000f0", s_resp_valid, s_resp_data);
        end
        tests++;
        if (grants.size() != 2 || grants[0] != FIRST_PRIO || grants[1] != 1 - FIRST_PRIO) begin
            fails++; $display("FAIL tie_order: got %0d grants expected order %0d,%0d",
                              grants.size(), FIRST_PRIO, 1 - FIRST_PRIO);
        end
        drain();
    endtask

    task automatic test_backpressure();
        rdy = 2'b00;
        set_req(1, 32'hFFFF_FFFF, 32'h2, 2'b11, 4'd0);
        cycle();
        set_req(0, 32'h10, 32'h20, 2'b11, 4'd0);
        cycle();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rdy = 2'b01;  // non-owner ready must be ignored
            cycle();
            tests++;
            if (s_resp_valid !== 2'b10 || s_resp_data !== 32'h1 || s_busy !== 1'b1 || s_req_ready !== 2'b00) begin
                fails++; $display("FAIL backpressure_hold %0d: got rv=%b rd=%h busy=%b rr=%b expected 10/00000001/1/00",
                                  i, s_resp_valid, s_resp_data, s_busy, s_req_ready);
            end
        end
        rdy = 2'b10;
        cycle();
        tests++;
        if (s_req_ready !== 2'b00) begin
            fails++; $display("FAIL backpressure_handshake_accept: got %b expected 00", s_req_ready);
        end
        cycle();
        tests++;
        if (s_req_ready !== 2'b01) begin
            fails++; $display("FAIL backpressure_waiter: got %b expected 01", s_req_ready);
        end
        drain();
    endtask

    task automatic test_shift();
        rdy = 2'b01;
        set_req(0, 32'hFF, 32'h00, 2'b01, 4'b0100);
        cycle();
        cycle();
        tests++;
        if (s_alu_shift !== 4'b0100) begin
            fails++; $display("FAIL shift_exec: got %b expected 0100", s_alu_shift);
        end
        cycle();
        tests++;
        if (s_resp_data !== 32'hF0) begin
            fails++; $display("FAIL shift_result: got %h expected 000000f0", s_resp_data);
        end
        drain();
    endtask

    task automatic test_contention();
        do_reset();
        grants.delete();
        accept_cyc.delete();
        refill = 2'b11;
        rdy    = 2'b11;
        new_req(0);
        new_req(1);
        repeat (12) cycle();
        refill = 2'b00;
        tests++;
        if (grants.size() != 4) begin
            fails++; $display("FAIL contention_count: got %0d expected 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (grants[i] != (FIRST_PRIO + i) % 2 || accept_cyc[i] - accept_cyc[0] != 3 * i) begin
                    fails++; $display("FAIL contention_grant %0d: got port %0d at +%0d expected port %0d at +%0d",
                                      i, grants[i], accept_cyc[i] - accept_cyc[0], (FIRST_PRIO + i) % 2, 3 * i);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_resp();
        int n = 0;
        rdy = 2'b00;
        new_req(0);
        do begin
            cycle();
            n++;
        end while (s_resp_valid !== 2'b01 && n < 10);
        tests++;
        if (s_resp_valid !== 2'b01) begin
            fails++; $display("FAIL midresp_wait: got %b expected 01", s_resp_valid);
        end
        do_reset();
        new_req(0);
        new_req(1);
        cycle();
        tests++;
        if (s_resp_valid !== 2'b00 || s_busy !== 1'b0 || s_alu_a !== 32'h0) begin
            fails++; $display("FAIL midresp_cleared: got rv=%b busy=%b a=%h expected 00/0/0",
                              s_resp_valid, s_busy, s_alu_a);
        end
        tests++;
        if (s_req_ready !== 2'(1 << FIRST_PRIO)) begin
            fails++; $display("FAIL midresp_tie: got %b expected grant to %0d", s_req_ready, FIRST_PRIO);
        end
        cycle();      // EXEC of the new op; reset drops it
        do_reset();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++)
                if (!pend_valid[p] && $urandom_range(0, 2) == 0) new_req(p);
            rdy = 2'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            cycle();
            rst = 1'b0;
        end
        drain();
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_shift();
        test_contention();
        test_reset_mid_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational 32-bit ALU (and/or/xor/add plus low-bit shift-mask stage) between two requesters, e.g. the instruction datapath (port 0) and the address/DMA unit (port 1). Round-robin arbitration accepts one request at a time and drives the ALU from registered operands. The arbiter captures the ALU result and returns it to the winning requester over a valid/ready response handshake. Only one operation is outstanding at any time.

Parameters:
DW, 32, operand/result width; must equal the ALU width (32).
FIRST_PRIO, 0, requester that wins a simultaneous request immediately after reset (0 or 1).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  2  per-requester request valid, bit i = requester i
req_a  in  2*DW  operand A; bits [DW*i+DW-1:DW*i] belong to requester i
req_b  in  2*DW  operand B, same packing
req_op  in  4  ALU op, 2 bits per requester (00 and, 01 or, 10 xor, 11 add)
req_shift  in  8  ALU shift control, 4 bits per requester
req_ready  out  2  request accepted this cycle (one-hot or zero)
resp_valid  out  2  result available for requester i (one-hot or zero)
resp_data  out  DW  result of the completed operation
resp_ready  in  2  requester i consumes the response
alu_a  out  DW  to ALU a
alu_b  out  DW  to ALU b
alu_op  out  2  to ALU op
alu_shift  out  4  to ALU shift
alu_out  in  DW  from ALU out (combinational)
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset: state IDLE; req_ready=0, resp_valid=0, resp_data=0, alu_a/alu_b/alu_op/alu_shift=0, busy=0, last_grant=~FIRST_PRIO.
- IDLE, no req_valid: stay; alu_* hold their previous values.
- IDLE, single req_valid[i]: winner = i.
- IDLE, both requests valid: winner = the requester that is not last_grant.
- req_ready[winner]=1 is combinational in IDLE only; req_ready=0 in EXEC and RESP.
- On the IDLE accept edge: latch the winner's a/b/op/shift into the alu_* registers; owner <= winner; go to EXEC.
- EXEC lasts exactly 1 cycle. At its edge: resp_data <= alu_out; resp_valid[owner] <= 1; last_grant <= owner; go to RESP.
- RESP: hold resp_data and resp_valid stable until resp_ready[owner]=1.
  - On that edge: resp_valid <= 0; go to IDLE.
  - resp_ready on the non-owner bit is ignored.
- Latency: accept edge to resp_valid high = 2 cycles. Minimum issue interval = 3 cycles (accept, EXEC, RESP with resp_ready already high).
- A request not granted keeps req_valid high; the arbiter never drops it. Requesters hold their request fields stable while req_valid=1 and req_ready=0.
- A request that arrives during EXEC/RESP waits; arbitration happens on the next IDLE cycle. No new accept can occur in the same cycle as the RESP handshake.
- Fairness: with both requesters asserting continuously, grants alternate 0,1,0,1…, starting with FIRST_PRIO.
- alu_* are registered and change only on accept edges or reset. The ALU sees stable inputs for the full EXEC cycle.
- Result arithmetic is entirely the ALU's: add wraps mod 2^32, no carry out; the arbiter does not modify alu_out.
- rst asserted in any state, including mid-EXEC or mid-RESP:
  - the transaction is dropped and no response is issued;
  - all registers return to reset values on that edge;
  - req_ready=0 during the reset cycle.
- req_valid=2'b00 in RESP has no effect.
- resp_ready high while resp_valid=0 has no effect.

Test Plan:
- Single request: port0 a=5, b=3, op=11, shift=0000 -> req_ready[0]=1 at cycle 0, resp_valid=01 at cycle 2, resp_data=8; resp_ready[0]=1 returns to IDLE at cycle 3.
- Simultaneous after reset (FIRST_PRIO=0): port0 and=0xF0&0x3C, port1 xor=0xFF^0x0F, both held valid -> port0 served first with 0x30; then port1 with 0xF0; grant order 0,1.
- Back-pressure: port1 add 0xFFFFFFFF+2 with resp_ready low for 5 cycles -> resp_data=0x00000001 held stable; resp_valid=10 throughout; busy=1; port0 request waiting gets req_ready=0 until the handshake.
- Shift path: port0 or a=0xFF, b=0x00, shift=0100 -> resp_data=0xF0; alu_shift=0100 during EXEC.
- Continuous contention: both valid for 12 cycles, resp_ready tied high -> 4 accepts alternating 0,1,0,1, one every 3 cycles.
- Reset mid-RESP: rst pulsed one cycle while resp_valid=01 -> next cycle resp_valid=00, busy=0, alu_a=0; a subsequent tie is granted to FIRST_PRIO.
